// File: rtl/fsm_arbiter_rr_if.sv
// fsm_arbiter_rr_if: request/grant bundle between the requesting masters and the arbiter
interface fsm_arbiter_rr_if #(
  parameter int N = 4,
  parameter int IDW = $clog2(N)
);
  logic [N-1:0] req;
  logic rr_en;
  logic [N-1:0] gnt;
  logic [IDW-1:0] gnt_id;
  logic busy;
  logic timeout;
  modport master (output req, rr_en, input gnt, gnt_id, busy, timeout);
  modport slave (input req, rr_en, output gnt, gnt_id, busy, timeout);
endinterface

// File: rtl/fsm_arbiter_rr.sv
// fsm_arbiter_rr: N-way fixed/round-robin grant-and-hold arbiter with optional hold-time preemption
module fsm_arbiter_rr #(
  parameter int N = 4,
  parameter int MAX_HOLD = 0,
  parameter int IDW = $clog2(N)
) (
  input logic clock,
  input logic reset,
  fsm_arbiter_rr_if.slave bus
);
  localparam int HW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  logic [0:0] state;
  logic [IDW-1:0] rr_ptr;
  logic [HW-1:0] hold_cnt;
  logic [N-1:0] skip;
  logic [N-1:0] elig;
  logic [IDW-1:0] win;
  logic [IDW-1:0] c;
  assign elig = bus.req & ~skip;
  // first eligible channel searching upward from 0 (fixed) or rr_ptr (round-robin), wrapping mod N
  always_comb begin
    win = '0;
    c = '0;
    for (int i = N - 1; i >= 0; i--) begin
      c = IDW'(((bus.rr_en ? int'(rr_ptr) : 0) + i) % N);
      if (elig[c]) win = c;
    end
  end
  // two-state FSM: arbitrate in IDLE, hold until release or preemption in GRANT
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      bus.gnt <= '0;
      bus.gnt_id <= '0;
      bus.busy <= 1'b0;
      bus.timeout <= 1'b0;
      rr_ptr <= '0;
      hold_cnt <= '0;
      skip <= '0;
    end else begin
      bus.timeout <= 1'b0;
      if (state == IDLE) begin
        skip <= '0;
        if (|elig) begin
          state <= GRANT;
          bus.gnt <= N'(1) << win;
          bus.gnt_id <= win;
          bus.busy <= 1'b1;
          hold_cnt <= HW'(1);
          if (bus.rr_en) rr_ptr <= (win == IDW'(N - 1)) ? '0 : win + 1'b1;
        end
      end else if (!bus.req[bus.gnt_id] || (MAX_HOLD != 0 && hold_cnt == HW'(MAX_HOLD))) begin
        state <= IDLE;
        bus.gnt <= '0;
        bus.gnt_id <= '0;
        bus.busy <= 1'b0;
        hold_cnt <= '0;
        bus.timeout <= bus.req[bus.gnt_id];
        skip <= bus.req[bus.gnt_id] ? N'(1) << bus.gnt_id : '0;
      end else if (~&hold_cnt) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end
endmodule

// File: doc/fsm_arbiter_rr.md
# fsm_arbiter_rr

Parametrised N-channel request/grant arbiter, the next generation of the team's 4-way fixed-priority FSM arbiter. It supports a run-time choice between fixed-priority and round-robin selection, holds a grant until the owner releases it, and optionally preempts an owner after a programmable maximum hold time. It sits between N requesting masters and one shared resource, and produces registered one-hot grants plus an encoded owner ID.

## Interface
- N, default 4: number of request channels, 2..16.
- MAX_HOLD, default 0: maximum consecutive grant cycles per ownership. 0 = unlimited (no preemption).
- IDW, default $clog2(N): width of gnt_id.
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  N  request per channel; level-sensitive, held high while service is wanted.
- rr_en  input  1  1 = round-robin, 0 = fixed priority (lowest index wins); sampled only in IDLE.
- gnt  output  N  registered one-hot grant; all zero when idle.
- gnt_id  output  IDW  index of current owner; 0 when idle.
- busy  output  1  high while in GRANT.
- timeout  output  1  one-cycle pulse when a grant is preempted by MAX_HOLD.

## Operation
- States: IDLE, GRANT. State, gnt, gnt_id, busy, timeout, rr_ptr (IDW bits), hold_cnt and skip mask (N bits) are all registers.
- Reset (sampled at a rising edge): state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, rr_ptr=0, hold_cnt=0, skip=0. Reset overrides everything, including mid-grant; the grant drops on that edge.
- IDLE, no eligible request: stay IDLE. Outputs stay 0.
- IDLE, eligible requests = req & ~skip nonzero:
  - Fixed mode: winner k = lowest set index.
  - RR mode: winner k = first set index searching rr_ptr, rr_ptr+1, … mod N.
  - Next state GRANT. gnt = one-hot(k), gnt_id = k, hold_cnt = 1.
  - In RR mode, rr_ptr = (k+1) mod N. In fixed mode, rr_ptr is unchanged.
  - skip is cleared.
- IDLE, req nonzero but all masked by skip: stay IDLE and clear skip. Arbitration happens on the next cycle.
- GRANT, req[gnt_id]=0: release. Next state IDLE, gnt=0, gnt_id=0, hold_cnt=0.
- GRANT, req[gnt_id]=1, MAX_HOLD≠0 and hold_cnt==MAX_HOLD: preempt.
  - Next state IDLE, gnt=0, timeout=1 for exactly one cycle.
  - skip = one-hot(gnt_id) in both modes, so the preempted channel is excluded from the next arbitration only.
- GRANT otherwise: hold the grant and increment hold_cnt. hold_cnt saturates at MAX_HOLD; when MAX_HOLD=0 it saturates at its all-ones value and never preempts.
- Requests on channels other than the owner are ignored during GRANT. There is no grant switch without an intervening IDLE cycle.
- rr_en changes during GRANT take effect at the next IDLE arbitration.
- Width rules:
  - rr_ptr wraps from N-1 to 0. For non-power-of-2 N, the increment is computed modulo N, not modulo 2^IDW.
  - hold_cnt width is $clog2(MAX_HOLD+1), minimum 1.

## Timing
- Grant latency: a request sampled high in IDLE at edge t produces gnt high after edge t, i.e. 1 cycle.
- Release latency: req dropped and sampled low at edge t produces gnt low after edge t.
- Minimum gap between successive grants: 1 IDLE cycle.
- With MAX_HOLD=M and a continuous request, gnt stays high exactly M cycles. timeout is high during the first IDLE cycle after that.
- A release and a preempt condition in the same cycle: release wins, and timeout stays 0.
- Outputs never glitch: all are driven directly from registers.

## Test plan
- Reset, then req=4'b0000 for 5 cycles -> gnt=0, busy=0, gnt_id=0, timeout=0 throughout.
- Fixed mode (rr_en=0), req=4'b1010 held -> gnt=4'b0010 one cycle later. Drop req[1] -> gnt=0 for 1 cycle, then gnt=4'b1000, gnt_id=3.
- RR mode, N=4, all four req held and each owner drops req after 2 cycles then reasserts -> grant order 0,1,2,3,0, each grant separated by one IDLE cycle.
- MAX_HOLD=3, req=4'b0011 held constantly, fixed mode -> gnt=0001 for 3 cycles, then timeout pulse with gnt=0, then gnt=0010 (ch0 skipped) for 3 cycles, then timeout, then ch0 again.
- Simultaneous release and hold_cnt==MAX_HOLD -> timeout stays 0 and skip stays clear; the next arbitration can grant the same channel.
- reset asserted mid-GRANT with N=5 in RR mode and rr_ptr=4 -> all outputs 0 after the edge. The first grant after reset searches from channel 0. Also check the wrap from 4 to 0 for non-power-of-2 N.
